// File: rtl/box_overlay_gen_pkg.sv
// Shared colour constants, palette, per-box state record and step selection
// for the box overlay generator.
package video_pkg;

    // Width of stored box coordinates; must match the generator's CNT_W.
    localparam int POS_W = 12;

    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_RED    = 24'hFF0000;
    localparam logic [23:0] C_ORANGE = 24'hFF8000;
    localparam logic [23:0] C_YELLOW = 24'hFFFF00;
    localparam logic [23:0] C_GREEN  = 24'h00FF00;
    localparam logic [23:0] C_BLUE   = 24'h0000FF;
    localparam logic [23:0] C_INDIGO = 24'h4B0082;
    localparam logic [23:0] C_VIOLET = 24'hEE82EE;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;

    // Ascending range so PALETTE[0] is the leftmost (RED) entry.
    localparam logic [0:7][23:0] PALETTE = {
        C_RED, C_ORANGE, C_YELLOW, C_GREEN, C_BLUE, C_INDIGO, C_VIOLET, C_WHITE
    };

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic             vx_neg;
        logic             vy_neg;
        logic [2:0]       cidx;
    } box_state_t;

    function automatic logic [POS_W-1:0] step_sel(input logic speed,
                                                  input int   slow,
                                                  input int   fast);
        return speed ? POS_W'(fast) : POS_W'(slow);
    endfunction

endpackage

// File: rtl/box_overlay_gen_if.sv
// Video-side bundle of the box overlay generator: timing inputs, box
// controls and the registered RGB / frame_tick outputs.
interface box_overlay_gen_if #(
    parameter int CNT_W   = 12,
    parameter int N_BOXES = 2
);
    logic               video_on;
    logic [CNT_W-1:0]   pixel_cnt;
    logic [CNT_W-1:0]   line_cnt;
    logic               v_sync;
    logic [N_BOXES-1:0] move_en;
    logic [N_BOXES-1:0] dcolor;
    logic [4:0]         move_dir;
    logic               speed;
    logic [7:0]         p_red;
    logic [7:0]         p_green;
    logic [7:0]         p_blue;
    logic               frame_tick;

    modport master (
        output video_on, pixel_cnt, line_cnt, v_sync,
        output move_en, dcolor, move_dir, speed,
        input  p_red, p_green, p_blue, frame_tick
    );

    modport slave (
        input  video_on, pixel_cnt, line_cnt, v_sync,
        input  move_en, dcolor, move_dir, speed,
        output p_red, p_green, p_blue, frame_tick
    );
endinterface

// File: rtl/box_overlay_gen_box_engine.sv
// One overlay box: position/motion with clamp or bounce, colour-advance latch
// and hit test. Build macro BOX_BORDER_EN blackens a 2-pixel rim of the box.
module box_engine
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int CNT_W     = 12,
    parameter int BOX_W     = 64,
    parameter int BOX_H     = 64,
    parameter int STEP_SLOW = 1,
    parameter int STEP_FAST = 4,
    parameter int IDX       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frame_tick,
    input  logic             i_move_en,
    input  logic             i_dcolor,
    input  logic [4:0]       i_move_dir,
    input  logic             i_speed,
    input  logic [CNT_W-1:0] i_pixel_cnt,
    input  logic [CNT_W-1:0] i_line_cnt,
    output logic             o_hit,
    output logic [23:0]      o_rgb
);
    // One extra bit so underflow shows up as a negative value.
    localparam int SW = CNT_W + 1;
    localparam logic signed [SW-1:0] X_MAX   = SW'(H_ACTIVE - BOX_W);
    localparam logic signed [SW-1:0] Y_MAX   = SW'(V_ACTIVE - BOX_H);
    localparam logic [POS_W-1:0]     X_MAX_P = POS_W'(H_ACTIVE - BOX_W);
    localparam logic [POS_W-1:0]     Y_MAX_P = POS_W'(V_ACTIVE - BOX_H);

    box_state_t r_state;
    logic       r_dcolor_d;
    logic       r_cpend;

    logic                 w_dcolor_rise;
    logic signed [SW-1:0] w_step;
    logic signed [SW-1:0] w_x;
    logic signed [SW-1:0] w_y;
    logic signed [SW-1:0] w_nx;
    logic signed [SW-1:0] w_ny;
    logic                 w_x_lo;
    logic                 w_x_hi;
    logic                 w_y_lo;
    logic                 w_y_hi;

    assign w_dcolor_rise = i_dcolor & ~r_dcolor_d;

    always_comb begin
        w_step = $signed(SW'(step_sel(i_speed, STEP_SLOW, STEP_FAST)));
        w_x    = $signed(SW'(r_state.x));
        w_y    = $signed(SW'(r_state.y));
        w_nx   = w_x;
        w_ny   = w_y;
        if (i_move_dir[4]) begin
            w_nx = r_state.vx_neg ? (w_x - w_step) : (w_x + w_step);
            w_ny = r_state.vy_neg ? (w_y - w_step) : (w_y + w_step);
        end else begin
            // Opposing direction bits cancel on their axis.
            if (i_move_dir[2] && !i_move_dir[3])
                w_nx = w_x - w_step;
            else if (i_move_dir[3] && !i_move_dir[2])
                w_nx = w_x + w_step;
            if (i_move_dir[0] && !i_move_dir[1])
                w_ny = w_y - w_step;
            else if (i_move_dir[1] && !i_move_dir[0])
                w_ny = w_y + w_step;
        end
        w_x_lo = w_nx[SW-1];
        w_x_hi = !w_nx[SW-1] && (w_nx > X_MAX);
        w_y_lo = w_ny[SW-1];
        w_y_hi = !w_ny[SW-1] && (w_ny > Y_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state.x      <= POS_W'(64 + 128 * IDX);
            r_state.y      <= POS_W'(64);
            r_state.vx_neg <= 1'b0;
            r_state.vy_neg <= 1'b0;
            r_state.cidx   <= 3'(IDX % 8);
            r_dcolor_d     <= 1'b0;
            r_cpend        <= 1'b0;
        end else begin
            r_dcolor_d <= i_dcolor;
            if (i_frame_tick) begin
                if (r_cpend)
                    r_state.cidx <= r_state.cidx + 3'd1;
                // An edge arriving on the tick itself waits for the next frame.
                r_cpend <= w_dcolor_rise;
                if (i_move_en) begin
                    r_state.x <= w_x_lo ? '0 : (w_x_hi ? X_MAX_P : w_nx[POS_W-1:0]);
                    r_state.y <= w_y_lo ? '0 : (w_y_hi ? Y_MAX_P : w_ny[POS_W-1:0]);
                    if (i_move_dir[4]) begin
                        if (w_x_lo || w_x_hi)
                            r_state.vx_neg <= ~r_state.vx_neg;
                        if (w_y_lo || w_y_hi)
                            r_state.vy_neg <= ~r_state.vy_neg;
                    end
                end
            end else if (w_dcolor_rise) begin
                r_cpend <= 1'b1;
            end
        end
    end

    logic [SW-1:0] w_px;
    logic [SW-1:0] w_ly;
    logic [SW-1:0] w_bx;
    logic [SW-1:0] w_by;

    assign w_px  = SW'(i_pixel_cnt);
    assign w_ly  = SW'(i_line_cnt);
    assign w_bx  = SW'(r_state.x);
    assign w_by  = SW'(r_state.y);
    assign o_hit = (w_px >= w_bx) && (w_px < w_bx + SW'(BOX_W)) &&
                   (w_ly >= w_by) && (w_ly < w_by + SW'(BOX_H));

`ifdef BOX_BORDER_EN
    logic w_border;
    assign w_border = (w_px <  w_bx + SW'(2)) || (w_px >= w_bx + SW'(BOX_W - 2)) ||
                      (w_ly <  w_by + SW'(2)) || (w_ly >= w_by + SW'(BOX_H - 2));
    assign o_rgb    = w_border ? C_BLACK : PALETTE[r_state.cidx];
`else
    assign o_rgb    = PALETTE[r_state.cidx];
`endif

endmodule

// File: rtl/box_overlay_gen.sv
// Colour-bar background with N_BOXES moving, colour-cycling boxes on top.
// Optional build macro BOX_BORDER_EN draws a black rim on the winning box.
module box_overlay_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int CNT_W     = 12,
    parameter int BARS      = 16,
    parameter int N_BOXES   = 2,
    parameter int BOX_W     = 64,
    parameter int BOX_H     = 64,
    parameter int STEP_SLOW = 1,
    parameter int STEP_FAST = 4
) (
    input  logic               rfr_clk,
    input  logic               reset_n,
    box_overlay_gen_if.slave   bus
);
    localparam int BAR_W     = H_ACTIVE / BARS;
    localparam int BAR_IDX_W = (BARS > 1) ? $clog2(BARS) : 1;

    logic r_vsync_d;
    logic w_frame_tick;

    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n)
            r_vsync_d <= 1'b0;
        else
            r_vsync_d <= bus.v_sync;
    end

    assign w_frame_tick   = bus.v_sync & ~r_vsync_d;
    assign bus.frame_tick = w_frame_tick;

    // Bar position: down-counter of pixels left in the current bar.
    logic [CNT_W-1:0]     r_bar_rem;
    logic [BAR_IDX_W-1:0] r_bar_idx;
    logic [BAR_IDX_W-1:0] w_bar_idx;
    logic                 w_line_start;

    assign w_line_start = (bus.pixel_cnt == '0);
    assign w_bar_idx    = w_line_start ? '0 : r_bar_idx;

    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bar_rem <= CNT_W'(BAR_W - 1);
            r_bar_idx <= '0;
        end else if (w_line_start) begin
            r_bar_rem <= CNT_W'(BAR_W - 2);
            r_bar_idx <= '0;
        end else if (r_bar_rem == '0) begin
            r_bar_rem <= CNT_W'(BAR_W - 1);
            if (r_bar_idx != BAR_IDX_W'(BARS - 1))
                r_bar_idx <= r_bar_idx + 1'b1;
        end else begin
            r_bar_rem <= r_bar_rem - 1'b1;
        end
    end

    logic [N_BOXES-1:0] w_hit;
    logic [23:0]        w_box_rgb [N_BOXES];

    genvar gi;
    generate
        for (gi = 0; gi < N_BOXES; gi++) begin : g_box
            box_engine #(
                .H_ACTIVE  (H_ACTIVE),
                .V_ACTIVE  (V_ACTIVE),
                .CNT_W     (CNT_W),
                .BOX_W     (BOX_W),
                .BOX_H     (BOX_H),
                .STEP_SLOW (STEP_SLOW),
                .STEP_FAST (STEP_FAST),
                .IDX       (gi)
            ) u_box (
                .clk          (rfr_clk),
                .rst_n        (reset_n),
                .i_frame_tick (w_frame_tick),
                .i_move_en    (bus.move_en[gi]),
                .i_dcolor     (bus.dcolor[gi]),
                .i_move_dir   (bus.move_dir),
                .i_speed      (bus.speed),
                .i_pixel_cnt  (bus.pixel_cnt),
                .i_line_cnt   (bus.line_cnt),
                .o_hit        (w_hit[gi]),
                .o_rgb        (w_box_rgb[gi])
            );
        end
    endgenerate

    logic        w_outside;
    logic [23:0] w_sel_rgb;
    logic [23:0] r_rgb;

    assign w_outside = (bus.pixel_cnt >= CNT_W'(H_ACTIVE)) ||
                       (bus.line_cnt  >= CNT_W'(V_ACTIVE));

    // Scan from the top index down so the lowest-index hit box wins.
    always_comb begin
        w_sel_rgb = PALETTE[3'(w_bar_idx)];
        for (int i = N_BOXES - 1; i >= 0; i--) begin
            if (w_hit[i])
                w_sel_rgb = w_box_rgb[i];
        end
        if (w_outside)
            w_sel_rgb = C_BLACK;
    end

    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n)
            r_rgb <= '0;
        else
            r_rgb <= bus.video_on ? w_sel_rgb : '0;
    end

    assign bus.p_red   = r_rgb[23:16];
    assign bus.p_green = r_rgb[15:8];
    assign bus.p_blue  = r_rgb[7:0];

endmodule

// File: tb/tb_box_overlay_gen.sv
// Self-checking bench for box_overlay_gen: directed steps plus random motion,
// checked against a frame-level behavioural model of the boxes and raster.
module tb_box_overlay_gen;
    import video_pkg::*;

    localparam int H = 1280;
    localparam int V = 720;
    localparam int NB = 2;
    localparam int BW = 64;
    localparam int BH = 64;
    localparam int NBARS = 16;
    localparam int BARW = H / NBARS;
    localparam int XMAX = H - BW;
    localparam int YMAX = V - BH;
    localparam logic [23:0] PAL [8] = '{24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
                                        24'h0000FF, 24'h4B0082, 24'hEE82EE, 24'hFFFFFF};

    logic rfr_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 rfr_clk = ~rfr_clk;

    box_overlay_gen_if #(.CNT_W(12), .N_BOXES(NB)) bus ();

    box_overlay_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12), .BARS(NBARS), .N_BOXES(NB),
        .BOX_W(BW), .BOX_H(BH), .STEP_SLOW(1), .STEP_FAST(4)
    ) dut (
        .rfr_clk (rfr_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail = 0;

    int mx [NB];
    int my [NB];
    int mc [NB];
    bit mvxn [NB];
    bit mvyn [NB];
    bit m_pend [NB];
    bit m_prev_dc [NB];
    bit m_prev_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rgb();
        return {bus.p_red, bus.p_green, bus.p_blue};
    endfunction

    function automatic box_state_t get_state(input int i);
        if (i == 0) return dut.g_box[0].u_box.r_state;
        return dut.g_box[1].u_box.r_state;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i] = 64 + 128 * i;
            my[i] = 64;
            mc[i] = i % 8;
            mvxn[i] = 0;
            mvyn[i] = 0;
            m_pend[i] = 0;
            m_prev_dc[i] = 0;
        end
        m_prev_vs = 0;
    endtask

    function automatic logic [23:0] model_color(input int p, input int l);
        int b;
        if (p >= H || l >= V) return 24'h0;
        for (int i = 0; i < NB; i++) begin
            if (p >= mx[i] && p < mx[i] + BW && l >= my[i] && l < my[i] + BH) begin
`ifdef BOX_BORDER_EN
                if (p < mx[i] + 2 || p >= mx[i] + BW - 2 || l < my[i] + 2 || l >= my[i] + BH - 2)
                    return 24'h0;
`endif
                return PAL[mc[i]];
            end
        end
        b = p / BARW;
        if (b > NBARS - 1) b = NBARS - 1;
        return PAL[b % 8];
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Box model update for one clock edge, from the current inputs.
    task automatic model_edge(input bit tk);
        int step, nx, ny, dx, dy;
        bit rise;
        step = bus.speed ? 4 : 1;
        for (int i = 0; i < NB; i++) begin
            rise = bus.dcolor[i] && !m_prev_dc[i];
            if (tk) begin
                if (m_pend[i]) mc[i] = (mc[i] + 1) % 8;
                m_pend[i] = rise;
                if (bus.move_en[i]) begin
                    if (bus.move_dir[4]) begin
                        nx = mvxn[i] ? mx[i] - step : mx[i] + step;
                        ny = mvyn[i] ? my[i] - step : my[i] + step;
                        if (nx < 0 || nx > XMAX) mvxn[i] = !mvxn[i];
                        if (ny < 0 || ny > YMAX) mvyn[i] = !mvyn[i];
                    end else begin
                        dx = int'(bus.move_dir[3]) - int'(bus.move_dir[2]);
                        dy = int'(bus.move_dir[1]) - int'(bus.move_dir[0]);
                        nx = mx[i] + dx * step;
                        ny = my[i] + dy * step;
                    end
                    mx[i] = clampi(nx, XMAX);
                    my[i] = clampi(ny, YMAX);
                end
            end else if (rise) begin
                m_pend[i] = 1;
            end
            m_prev_dc[i] = bus.dcolor[i];
        end
        m_prev_vs = bus.v_sync;
    endtask

    task automatic cyc();
        logic [23:0] e;
        bit tk;
        #1;
        tk = bus.v_sync && !m_prev_vs;
        check("frame_tick", 32'(bus.frame_tick), 32'(tk));
        e = bus.video_on ? model_color(int'(bus.pixel_cnt), int'(bus.line_cnt)) : 24'h0;
        model_edge(tk);
        @(posedge rfr_clk);
        #1;
        check("rgb", 32'(rgb()), 32'(e));
    endtask

    task automatic do_frame();
        bus.pixel_cnt = '0;
        bus.video_on = 1'b0;
        bus.v_sync = 1'b1;
        cyc();
        cyc();
        bus.v_sync = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic sweep(input int line, input int from, input int to, input bit rnd_von);
        bus.line_cnt = 12'(line);
        for (int p = from; p <= to; p++) begin
            bus.pixel_cnt = 12'(p);
            bus.video_on = rnd_von ? ($urandom_range(0, 9) != 0) : 1'b1;
            cyc();
        end
    endtask

    task automatic check_boxes(input string tag);
        box_state_t s;
        for (int i = 0; i < NB; i++) begin
            s = get_state(i);
            check({tag, "_x"}, 32'(s.x), 32'(mx[i]));
            check({tag, "_y"}, 32'(s.y), 32'(my[i]));
            check({tag, "_vxn"}, 32'(s.vx_neg), 32'(mvxn[i]));
            check({tag, "_vyn"}, 32'(s.vy_neg), 32'(mvyn[i]));
            check({tag, "_cidx"}, 32'(s.cidx), 32'(mc[i]));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_rgb", 32'(rgb()), 32'h0);
        check("rst_x0", 32'(get_state(0).x), 32'd64);
        check("rst_x1", 32'(get_state(1).x), 32'd192);
        check("rst_y0", 32'(get_state(0).y), 32'd64);
        m_reset();
        bus.pixel_cnt = '0;
        bus.video_on = 1'b0;
        bus.v_sync = 1'b0;
        bus.dcolor = '0;
        @(posedge rfr_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.video_on = 1'b0;
        bus.pixel_cnt = '0;
        bus.line_cnt = '0;
        bus.v_sync = 1'b0;
        bus.move_en = '0;
        bus.dcolor = '0;
        bus.move_dir = '0;
        bus.speed = 1'b0;
        m_reset();
        repeat (3) @(posedge rfr_clk);
        #1;
        check("reset_rgb", 32'(rgb()), 32'h0);
        check("reset_ft", 32'(bus.frame_tick), 32'h0);
        check_boxes("reset");
        reset_n = 1'b1;

        // Background bars on line 0.
        sweep(0, 0, 0, 0);
        check("bar0_red", 32'(rgb()), 32'hFF0000);
        sweep(0, 1, 80, 0);
        check("bar1_orange", 32'(rgb()), 32'hFF8000);
        sweep(0, 81, 640, 0);
        check("bar8_red", 32'(rgb()), 32'hFF0000);
        sweep(0, 641, 1283, 0);
        check("past_h_black", 32'(rgb()), 32'h0);
        sweep(800, 0, 20, 0);

        // Box0 manual right.
        bus.move_en = 2'b01;
        bus.move_dir = 5'b01000;
        bus.speed = 1'b0;
        repeat (3) do_frame();
        check("x0_slow3", 32'(get_state(0).x), 32'd67);
        bus.speed = 1'b1;
        do_frame();
        check("x0_fast1", 32'(get_state(0).x), 32'd71);
        check_boxes("manual_right");

        // Box1 left to the clamp.
        bus.move_en = 2'b10;
        bus.move_dir = 5'b00100;
        repeat (60) do_frame();
        check("x1_clamp0", 32'(get_state(1).x), 32'd0);
        check_boxes("left_clamp");

        // Box0 to x=1213, then auto bounce.
        bus.move_en = 2'b01;
        bus.move_dir = 5'b01000;
        bus.speed = 1'b1;
        repeat (285) do_frame();
        bus.speed = 1'b0;
        repeat (2) do_frame();
        check("x0_1213", 32'(get_state(0).x), 32'd1213);
        bus.move_dir = 5'b10000;
        bus.speed = 1'b1;
        do_frame();
        check("auto_x0_edge", 32'(get_state(0).x), 32'd1216);
        check("auto_vxn", 32'(get_state(0).vx_neg), 32'd1);
        check("auto_y0", 32'(get_state(0).y), 32'd68);
        do_frame();
        check("auto_x0_back", 32'(get_state(0).x), 32'd1212);
        check_boxes("auto");

        // Random motion and colour requests.
        repeat (40) begin
            bus.move_en = 2'($urandom);
            bus.move_dir = 5'($urandom);
            bus.speed = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                bus.dcolor = 2'($urandom);
                cyc();
                bus.dcolor = '0;
                cyc();
            end
            do_frame();
            check_boxes("rand");
        end
        for (int k = 0; k < 3; k++) begin
            sweep(my[k % NB] + $urandom_range(0, 70), 0, 1283, 1);
        end

        // Overlap: box1 slides under box0 at (100,100).
        do_reset();
        bus.move_en = 2'b10;
        bus.move_dir = 5'b00100;
        bus.speed = 1'b1;
        repeat (24) do_frame();
        check("x1_96", 32'(get_state(1).x), 32'd96);
        sweep(100, 0, 100, 0);
        check("overlap_red", 32'(rgb()), 32'hFF0000);
        sweep(100, 101, 200, 0);

        // Two dcolor edges in one frame advance the colour once.
        bus.move_en = '0;
        bus.dcolor = 2'b01;
        cyc();
        bus.dcolor = 2'b00;
        cyc();
        bus.dcolor = 2'b01;
        cyc();
        bus.dcolor = 2'b00;
        cyc();
        do_frame();
        check("cidx0_once", 32'(get_state(0).cidx), 32'd1);
        check_boxes("dcolor");
        sweep(100, 0, 100, 0);
        check("overlap_orange", 32'(rgb()), 32'hFF8000);

        // video_on low inside a box, then mid-line reset.
        bus.pixel_cnt = 12'd101;
        bus.video_on = 1'b0;
        cyc();
        check("von0_black", 32'(rgb()), 32'h0);
        sweep(100, 102, 110, 0);
        check("pre_reset", 32'(rgb()), 32'hFF8000);
        do_reset();
        check_boxes("post_reset");
        sweep(100, 0, 130, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
